// File: rtl/data_lsu.sv
// Load/store unit between execute and a word-addressed data SRAM without byte enables.
// Sub-word stores are performed as read-modify-write; every request gets exactly one response pulse.
module data_lsu #(
  parameter int MEM_WORDS = 10
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_MERGE  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  logic [1:0]  state_reg, state_next;
  logic        we_reg, uns_reg, err_reg;
  logic [1:0]  size_reg, addr_lo_reg;
  logic [15:0] wdata_reg;
  logic [29:0] word_idx_reg;
  logic [31:0] data_wdata_reg, rdata_reg;

  logic        accept, req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext, merged_word;
  logic [3:0]  lane_sel;

  assign accept = lsu_req_i & (state_reg == ST_IDLE);

  always_comb begin
    req_err = 1'b0;
    case (lsu_size_i)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = lsu_addr_i[0];
      SZ_W:    req_err = |lsu_addr_i[1:0];
      default: req_err = 1'b1;
    endcase
    if (lsu_addr_i[31:2] >= WORD_LIMIT) req_err = 1'b1;
  end

  always_comb begin
    load_byte = data_rdata_i[8*addr_lo_reg +: 8];
    load_half = data_rdata_i[16*addr_lo_reg[1] +: 16];
    case (size_reg)
      SZ_B:    load_ext = {{24{~uns_reg & load_byte[7]}}, load_byte};
      SZ_H:    load_ext = {{16{~uns_reg & load_half[15]}}, load_half};
      default: load_ext = data_rdata_i;
    endcase
  end

  // Replace only the addressed byte lanes of the old SRAM word with the store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_sel[gi] = (size_reg == SZ_B) ? (addr_lo_reg == 2'(gi))
                                               : (addr_lo_reg[1] == 1'(gi / 2));
      assign merged_word[8*gi +: 8] =
        !lane_sel[gi]       ? data_rdata_i[8*gi +: 8] :
        (size_reg == SZ_B)  ? wdata_reg[7:0]          :
                              wdata_reg[8*(gi % 2) +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_next = (we_reg && size_reg != SZ_W) ? ST_MERGE : ST_RESP;
      ST_MERGE:  state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      uns_reg        <= 1'b0;
      err_reg        <= 1'b0;
      size_reg       <= 2'd0;
      addr_lo_reg    <= 2'd0;
      wdata_reg      <= 16'd0;
      word_idx_reg   <= 30'd0;
      data_wdata_reg <= 32'd0;
      rdata_reg      <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            we_reg      <= lsu_we_i;
            uns_reg     <= lsu_unsigned_i;
            size_reg    <= lsu_size_i;
            addr_lo_reg <= lsu_addr_i[1:0];
            wdata_reg   <= lsu_wdata_i[15:0];
            err_reg     <= req_err;
            rdata_reg   <= 32'd0;
            // SRAM-facing registers only move for requests that will reach the SRAM.
            if (!req_err) begin
              word_idx_reg <= lsu_addr_i[31:2];
              if (lsu_we_i && lsu_size_i == SZ_W) data_wdata_reg <= lsu_wdata_i;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_reg)               rdata_reg      <= load_ext;
          else if (size_reg != SZ_W) data_wdata_reg <= merged_word;
        end
        ST_RESP: begin
          rdata_reg <= 32'd0;
          err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign lsu_gnt_o    = (state_reg == ST_IDLE);
  assign lsu_rvalid_o = (state_reg == ST_RESP);
  assign lsu_rdata_o  = rdata_reg;
  assign lsu_err_o    = err_reg;

  assign data_req_o   = (state_reg == ST_ACCESS) || (state_reg == ST_MERGE);
  assign data_we_o    = (state_reg == ST_MERGE) ||
                        ((state_reg == ST_ACCESS) && we_reg && size_reg == SZ_W);
  assign data_addr_o  = {2'b00, word_idx_reg};
  assign data_wdata_o = data_wdata_reg;

endmodule

// File: doc/data_lsu.md
# data_lsu

Load/store unit that sits between the core's execute stage and the word-addressed data SRAM. It accepts one byte, halfword or word access at a time and checks alignment and range. Loads are sign- or zero-extended. The SRAM has no byte enables, so sub-word stores are done as read-modify-write. Each request completes with exactly one response pulse.

## Interface
- MEM_WORDS, 10, number of 32-bit words in the data SRAM; valid word indices are 0..MEM_WORDS-1.
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- lsu_req_i  in  1  request valid from execute.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- lsu_unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- lsu_gnt_o  out  1  request accepted this cycle (lsu_req_i & lsu_gnt_o at a rising edge).
- lsu_rvalid_o  out  1  one-cycle response pulse.
- lsu_rdata_o  out  32  load result; 0 for stores and errors.
- lsu_err_o  out  1  misaligned, out-of-range or bad size; valid with lsu_rvalid_o.
- data_req_o  out  1  SRAM request.
- data_we_o  out  1  SRAM write enable.
- data_addr_o  out  32  SRAM word index, equal to {2'b0, addr[31:2]}.
- data_wdata_o  out  32  SRAM write word.
- data_rdata_i  in  32  SRAM read word; combinational from data_addr_o in the same cycle.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
  - In IDLE, lsu_gnt_o = 1. On accept, the unit latches we, size, unsigned, addr and wdata.
- Error check at accept. Any of the following is an error:
  - size 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - addr[31:2] ≥ MEM_WORDS.
- On error the FSM goes IDLE→RESP with err = 1 and rdata = 0. No data_req_o is issued.
- ACCESS drives data_req_o = 1 and data_addr_o = latched word index.
  - Load: data_we_o = 0. The unit registers the extracted and extended data_rdata_i at the end of the cycle, then goes to RESP.
  - Word store: data_we_o = 1 and data_wdata_o = latched wdata; the write commits at the ACCESS→RESP edge.
  - Sub-word store: data_we_o = 0. The unit registers data_rdata_i as the old word, then goes to MERGE.
- MERGE drives data_req_o = 1, data_we_o = 1 and data_wdata_o = old word with the target lane replaced, then goes to RESP.
- RESP asserts lsu_rvalid_o = 1 for one cycle with lsu_gnt_o = 0, then returns to IDLE.
- Lane rules, little-endian:
  - A byte occupies bits [8k+7:8k] with k = addr[1:0].
  - A halfword occupies bits [16h+15:16h] with h = addr[1].
  - Loads extend to 32 bits from bit 7 (byte) or bit 15 (halfword) unless unsigned. Word loads pass through unchanged.
- data_* outputs depend only on the FSM state and latched registers. There is no combinational path from lsu_* inputs to data_* outputs.
- Outside ACCESS/MERGE: data_req_o = 0, data_we_o = 0, data_addr_o and data_wdata_o hold their last values (don't-care to the SRAM).

## Timing
- Reset values:
  - state = IDLE, so lsu_gnt_o = 1;
  - lsu_rvalid_o = 0, lsu_err_o = 0, lsu_rdata_o = 0;
  - data_req_o = 0, data_we_o = 0, data_addr_o = 0, data_wdata_o = 0.
- Let cycle 0 be the accept cycle. lsu_rvalid_o is asserted in:
  - error: cycle 1;
  - load or word store: cycle 2;
  - sub-word store: cycle 3.
- Throughput is one request per 2/3/4 cycles respectively. lsu_gnt_o is low from cycle 1 until the response cycle has passed.
- While lsu_gnt_o = 0, lsu_req_i and all operand inputs are ignored. The requester holds them until it sees gnt.
- A new request may be accepted in the cycle immediately after RESP.
  - A load that immediately follows a store to the same word returns the stored value, because the write committed before RESP.
- Reset asserted in any state:
  - the FSM returns to IDLE immediately;
  - any pending MERGE write is dropped and no data_we_o pulse occurs;
  - no response is produced for the aborted request.
- lsu_rdata_o and lsu_err_o are meaningful only while lsu_rvalid_o = 1. They return to 0 in the cycle after RESP.

## Test plan
Scenarios use the testbench SRAM reset image: word0 = 0x0000000F, word5 = 0x00F00000, word7 = 0xF0000000, word8 = 0x0A0A0A0A.
- LW at 0x14 → lsu_rdata_o = 0x00F00000, err = 0, rvalid exactly in cycle 2, data_addr_o = 5 during ACCESS.
- LB at 0x1F, signed → 0xFFFFFFF0. LBU at 0x1F → 0x000000F0. LHU at 0x1E → 0x0000F000. LH at 0x1E → 0xFFFFF000.
- SB 0x55 at 0x21 → one read cycle, then one write cycle with data_wdata_o = 0x0A0A550A; rvalid in cycle 3. A following LW at 0x20 returns 0x0A0A550A.
- Error cases, each giving rvalid in cycle 1 with err = 1, rdata = 0 and data_req_o never high:
  - LH at 0x03;
  - SW at 0x02;
  - LW at 0x28 (word 10, out of range);
  - size 11.
- Back-to-back traffic with lsu_req_i held high: SW 0xDEADBEEF at 0x00, then LW at 0x00 accepted in the cycle after RESP → returns 0xDEADBEEF. lsu_gnt_o pattern is 1,0,0,1.
- Reset mid-store: SH at 0x20, rstn_i pulled low during ACCESS and released → no data_we_o pulse, no rvalid, lsu_gnt_o = 1, word8 unchanged.
